fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Display-side reader for frame_buffer; sits directly downstream of it.
- Generates 640x480 VGA-class raster timing on the pixel clock and drives frame_buffer's read address for an IMG_W x IMG_H image window centred on screen.
- Realigns syncs with the synchronous read data and emits RGB565 pixels with hsync/vsync/de.

Parameters:
ADDR_WIDTH, 32, frame_buffer address width
DATA_WIDTH, 16, pixel width (RGB565)
IMG_W, 128, image width in pixels (multiple of 8)
IMG_H, 80, image height in lines (IMG_W*IMG_H = 10240 = 10 BRAM x 1024)
IMG_X0, 256, first image column on screen
IMG_Y0, 200, first image line on screen
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
SYNC_POL, 0, active level of hsync_o/vsync_o
RD_LATENCY, 1, frame_buffer read latency in clocks
BORDER_COLOR, 16'h0000, colour outside image window

Ports:
clk_i  in  1  pixel clock; same clock as frame_buffer
resetn_i  in  1  asynchronous reset, active-low
enable_i  in  1  scanout run; low holds raster at (0,0)
addr_rd_o  out  ADDR_WIDTH  read address to frame_buffer addr_rd
fb_data_i  in  DATA_WIDTH  frame_buffer Data_out
hsync_o  out  1  horizontal sync
vsync_o  out  1  vertical sync
de_o  out  1  active-video data enable
rgb_o  out  DATA_WIDTH  output pixel
frame_start_o  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Counters h_cnt 0..799 and v_cnt 0..524 are registered; h wraps to 0 and increments v; v wraps to 0 after 524.
- Stage 0 (counter cycle) signals:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - in_win = IMG_X0<=h<IMG_X0+IMG_W && IMG_Y0<=v<IMG_Y0+IMG_H.
  - hs = H_ACTIVE+H_FP<=h<H_ACTIVE+H_FP+H_SYNC; vs is defined likewise on v.
- Address generation uses no multiplier:
  - row_base register; col register.
  - addr_rd_o = row_base+col when in_win, else 0. Combinational from registers, presented in the stage-0 cycle.
  - col increments per in_win pixel and clears at the window's right edge.
  - row_base += IMG_W after the last window pixel of each image line.
  - row_base clears at frame wrap.
  - Last address is IMG_W*IMG_H-1 (10239); addr_rd_o never reaches IMG_W*IMG_H.
- Alignment: active, in_win, hs, vs and sof pass through a RD_LATENCY-deep delay line, where sof = (h==0 && v==0).
- Output register stage updates every clk_i:
  - de_o = active_d.
  - rgb_o = fb_data_i if in_win_d; BORDER_COLOR if active_d && !in_win_d; 0 if !active_d.
  - hsync_o = hs_d ? SYNC_POL : ~SYNC_POL; vsync_o likewise from vs_d.
  - frame_start_o = sof_d.
- Total latency counter->outputs = RD_LATENCY+1 clocks (2 by default). addr_rd_o leads rgb_o by exactly that.
- Reset (async, resetn_i=0):
  - Counters, row_base, col and delay line clear.
  - addr_rd_o=0, de_o=0, rgb_o=0, frame_start_o=0.
  - hsync_o=vsync_o=~SYNC_POL.
  - Takes effect immediately, including mid-line.
- enable_i=0 (sampled per clock):
  - Counters, row_base and col are forced to 0. Stage-0 flags are forced inactive (sof included).
  - Delay line keeps shifting, so outputs go inactive after RD_LATENCY+1 clocks.
  - On re-enable, raster restarts at (0,0) and frame_start_o pulses 2 clocks later.
  - Mid-frame deassert is permitted and discards the partial frame.
- fb_data_i is ignored whenever in_win_d=0.

Optional Feature:
FB_SCANOUT_TEST_PATTERN_EN
- Defined: adds input pattern_sel_i (1 bit).
  - When pattern_sel_i=1, in-window pixels ignore fb_data_i. Bar index = col/(IMG_W/8), delayed with the pipeline.
  - Bars in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - addr_rd_o behaves unchanged.
- Undefined: port absent; rgb_o always taken from fb_data_i in window.

Test Plan:
- Timing, enable_i=1 after reset:
  - Output hsync_o is low (SYNC_POL=0) for 96 clocks starting 656+2 clocks after h_cnt=0; period 800 clocks.
  - vsync_o is low for 1600 clocks per 420000.
  - de_o is high for 640 clocks per line, 480 lines.
- Address sequence:
  - (h=256,v=200) -> addr_rd_o=0; (383,200) -> 127.
  - (256,201) -> 128; (383,279) -> 10239.
  - (255,200) and (256,280) -> 0.
- Data alignment, with a memory model returning addr[15:0]^16'h5A5A after 1 clock:
  - Output pixel (256,200) rgb_o=5A5A; (383,279) rgb_o=7DA5.
  - Output pixel (100,100) rgb_o=0000 with de_o=1.
  - frame_start_o is coincident with output pixel (0,0).
- enable_i dropped at line 240:
  - de_o=0 and syncs inactive within 2 clocks.
  - Re-enable -> frame_start_o pulses 2 clocks later; first window address is 0 again.
- resetn_i pulsed low mid-line at (300,210):
  - All outputs take reset values asynchronously.
  - After release, raster restarts at (0,0) with addr_rd_o=0.
- FB_SCANOUT_TEST_PATTERN_EN defined, pattern_sel_i=1:
  - Output columns 256..271 = FFFF, 272..287 = FFE0, …, 368..383 = 0000.
  - Border remains BORDER_COLOR.

Source files
------------

// File: rtl/fb_scanout_if.sv
// fb_scanout <-> frame_buffer read port.
// Synchronous read: data follows addr_rd by the buffer's read latency.
interface fb_scanout_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [DATA_WIDTH-1:0] fb_data;

  modport master (
    output addr_rd,
    input  fb_data
  );

  modport slave (
    input  addr_rd,
    output fb_data
  );
endinterface

// File: rtl/fb_scanout.sv
// VGA-class raster scanout reading a centred image window from frame_buffer.
// Optional colour-bar generator: define FB_SCANOUT_TEST_PATTERN_EN.
module fb_scanout #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W = 128,
  parameter int IMG_H = 80,
  parameter int IMG_X0 = 256,
  parameter int IMG_Y0 = 200,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = '0
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  enable_i,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  input  logic                  pattern_sel_i,
`endif
  fb_scanout_if.master          fb,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] rgb_o,
  output logic                  frame_start_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT + 1);
  localparam int VW = $clog2(V_TOT + 1);

  typedef logic [HW-1:0] h_t;
  typedef logic [VW-1:0] v_t;
  typedef logic [ADDR_WIDTH-1:0] a_t;

  localparam h_t H_LAST = h_t'(H_TOT - 1);
  localparam h_t H_ACT  = h_t'(H_ACTIVE);
  localparam h_t H_SS   = h_t'(H_ACTIVE + H_FP);
  localparam h_t H_SE   = h_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam h_t H_WS   = h_t'(IMG_X0);
  localparam h_t H_WE   = h_t'(IMG_X0 + IMG_W);
  localparam h_t H_WL   = h_t'(IMG_X0 + IMG_W - 1);
  localparam v_t V_LAST = v_t'(V_TOT - 1);
  localparam v_t V_ACT  = v_t'(V_ACTIVE);
  localparam v_t V_SS   = v_t'(V_ACTIVE + V_FP);
  localparam v_t V_SE   = v_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam v_t V_WS   = v_t'(IMG_Y0);
  localparam v_t V_WE   = v_t'(IMG_Y0 + IMG_H);
  localparam a_t ROW_STEP = a_t'(IMG_W);

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  localparam int DW = 8;
`else
  localparam int DW = 5;
`endif

  h_t h_cnt;
  v_t v_cnt;
  a_t row_base;
  a_t col;

  logic act, win, hs, vs, sof;
  logic h_wrap, f_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign f_wrap = h_wrap && (v_cnt == V_LAST);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= f_wrap ? '0 : v_cnt + v_t'(1);
    end else begin
      h_cnt <= h_cnt + h_t'(1);
    end
  end

  // Disabled raster presents an all-inactive stage 0.
  assign act = enable_i && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign win = enable_i
            && (h_cnt >= H_WS) && (h_cnt < H_WE)
            && (v_cnt >= V_WS) && (v_cnt < V_WE);
  assign hs  = enable_i && (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs  = enable_i && (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign sof = enable_i && (h_cnt == '0) && (v_cnt == '0);

  assign fb.addr_rd = win ? row_base + col : '0;

  // Linear address built by accumulation instead of y*IMG_W.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      row_base <= '0;
      col      <= '0;
    end else if (!enable_i) begin
      row_base <= '0;
      col      <= '0;
    end else begin
      if (win) begin
        if (h_cnt == H_WL) begin
          col      <= '0;
          row_base <= row_base + ROW_STEP;
        end else begin
          col <= col + a_t'(1);
        end
      end
      if (f_wrap) begin
        row_base <= '0;
      end
    end
  end

  logic [DW-1:0] s0;
  logic [DW-1:0] d;
  logic [DW-1:0] dly [RD_LATENCY];

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = IMG_W / 8;
  logic [2:0] bar;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (col >= a_t'(k * BAR_W)) begin
        bar = 3'(k);
      end
    end
  end

  assign s0 = {bar, sof, vs, hs, win, act};
`else
  assign s0 = {sof, vs, hs, win, act};
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        dly[i] <= '0;
      end
    end else begin
      dly[0] <= s0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign d = dly[RD_LATENCY-1];

  logic [DATA_WIDTH-1:0] pix;

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  function automatic logic [DATA_WIDTH-1:0] bar_color(
    input logic [2:0] b
  );
    logic [15:0] c;
    unique case (b)
      3'd0: c = 16'hFFFF;
      3'd1: c = 16'hFFE0;
      3'd2: c = 16'h07FF;
      3'd3: c = 16'h07E0;
      3'd4: c = 16'hF81F;
      3'd5: c = 16'hF800;
      3'd6: c = 16'h001F;
      3'd7: c = 16'h0000;
    endcase
    return DATA_WIDTH'(c);
  endfunction

  assign pix = pattern_sel_i ? bar_color(d[7:5]) : fb.fb_data;
`else
  assign pix = fb.fb_data;
`endif

  // d = {sof, vs, hs, win, act}, aligned with fb_data.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      de_o          <= 1'b0;
      rgb_o         <= '0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      frame_start_o <= 1'b0;
    end else begin
      de_o <= d[0];
      if (d[1]) begin
        rgb_o <= pix;
      end else if (d[0]) begin
        rgb_o <= BORDER_COLOR;
      end else begin
        rgb_o <= '0;
      end
      hsync_o       <= d[2] ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= d[3] ? SYNC_POL : ~SYNC_POL;
      frame_start_o <= d[4];
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout on a reduced raster.
// Reference model derives everything from the raster position.
`timescale 1ns/1ps
module tb_fb_scanout;
  localparam int HA = 96, HFP = 8, HS = 12, HBP = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VA = 40, VFP = 2, VS = 3, VBP = 5;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int W = 32, H = 10, X0 = 40, Y0 = 12;
  localparam int FR = HT * VT;
  localparam int NPIX = W * H;
  localparam logic [15:0] BORDER = 16'h1234;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic nxt_en = 1'b0;
  logic psel = 1'b0;
  logic hsync, vsync, de, fs;
  logic [15:0] rgb;
  logic [19:0] obs;

  fb_scanout_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) fbi ();

  always #5 clk = ~clk;

  fb_scanout #(
    .ADDR_WIDTH(32), .DATA_WIDTH(16),
    .IMG_W(W), .IMG_H(H), .IMG_X0(X0), .IMG_Y0(Y0),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .RD_LATENCY(1), .BORDER_COLOR(BORDER)
  ) dut (
    .clk_i(clk),
    .resetn_i(rst_n),
    .enable_i(en),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    .pattern_sel_i(psel),
`endif
    .fb(fbi),
    .hsync_o(hsync),
    .vsync_o(vsync),
    .de_o(de),
    .rgb_o(rgb),
    .frame_start_o(fs)
  );

  assign obs = {de, hsync, vsync, fs, rgb};

  logic [15:0] mem [NPIX];
  logic [15:0] bars [8];

  // frame_buffer model: one clock read latency
  always @(posedge clk) begin
    if (fbi.addr_rd < 32'(NPIX))
      fbi.fb_data <= mem[int'(fbi.addr_rd)];
    else
      fbi.fb_data <= 16'hDEAD;
  end

  typedef struct packed {
    logic en, act, win, hs, vs, sof;
    int h;
    int v;
    logic [31:0] addr;
    logic [2:0] bar;
  } rec_t;

  rec_t cur, h1, h2;
  int ticks = 0;
  int checks = 0;
  int fails = 0;

  function automatic rec_t mk_rec(int t, logic e);
    rec_t r;
    int hh, vv;
    r = '0;
    if (e) begin
      hh = t % HT;
      vv = t / HT;
      r.en  = 1'b1;
      r.h   = hh;
      r.v   = vv;
      r.act = (hh < HA) && (vv < VA);
      r.win = (hh >= X0) && (hh < X0 + W)
           && (vv >= Y0) && (vv < Y0 + H);
      r.hs  = (hh >= HA + HFP) && (hh < HA + HFP + HS);
      r.vs  = (vv >= VA + VFP) && (vv < VA + VFP + VS);
      r.sof = (t == 0);
      if (r.win) begin
        r.addr = 32'((vv - Y0) * W + (hh - X0));
        r.bar  = 3'((hh - X0) / (W / 8));
      end
    end
    return r;
  endfunction

  function automatic logic [19:0] exp_out(rec_t r);
    logic [15:0] px;
    if (r.win) px = psel ? bars[r.bar] : mem[int'(r.addr)];
    else if (r.act) px = BORDER;
    else px = 16'h0000;
    return {r.act, ~r.hs, ~r.vs, r.sof, px};
  endfunction

  // One clock: advance model at the edge, return at the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
    h2 = h1;
    h1 = cur;
    if (!rst_n) begin
      h1 = '0;
      h2 = '0;
      ticks = 0;
    end else if (en) begin
      ticks = (ticks + 1) % FR;
    end else begin
      ticks = 0;
    end
    en = nxt_en;
    cur = mk_rec(ticks, en);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    nxt_en = 1'b0;
    repeat (3) adv();
    checks++;
    if (obs !== 20'h60000 || fbi.addr_rd !== 32'd0) begin
      fails++;
      $display("FAIL reset_state out=%h addr=%0d want out=60000 addr=0",
               obs, fbi.addr_rd);
    end
    nxt_en = 1'b1;
    adv();
    checks++;
    if (obs !== 20'h60000 || fbi.addr_rd !== 32'd0) begin
      fails++;
      $display("FAIL reset_hold_en out=%h addr=%0d want out=60000 addr=0",
               obs, fbi.addr_rd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int de_n, hs_n, vs_n, fs_n, first_hs;
    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; first_hs = -1;
    for (int c = 1; c <= FR + 2; c++) begin
      adv();
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL timing_px t=%0t out=%h want=%h addr=%0d want=%0d",
                   $time, obs, exp_out(h2), fbi.addr_rd, cur.addr);
      end
      if (c > 2) begin
        if (de) de_n++;
        if (!hsync) hs_n++;
        if (!vsync) vs_n++;
        if (fs) fs_n++;
      end
      if (first_hs < 0 && !hsync) first_hs = c;
      if (c == 2) begin
        checks++;
        if (fs !== 1'b1) begin
          fails++;
          $display("FAIL first_frame_start fs=%b want=1", fs);
        end
      end
    end
    checks++;
    if (de_n != HA * VA) begin
      fails++;
      $display("FAIL de_count got=%0d want=%0d", de_n, HA * VA);
    end
    checks++;
    if (hs_n != HS * VT) begin
      fails++;
      $display("FAIL hsync_count got=%0d want=%0d", hs_n, HS * VT);
    end
    checks++;
    if (vs_n != VS * HT) begin
      fails++;
      $display("FAIL vsync_count got=%0d want=%0d", vs_n, VS * HT);
    end
    checks++;
    if (fs_n != 1) begin
      fails++;
      $display("FAIL fs_count got=%0d want=1", fs_n);
    end
    checks++;
    if (first_hs != HA + HFP + 2) begin
      fails++;
      $display("FAIL hsync_start got=%0d want=%0d", first_hs, HA + HFP + 2);
    end
  endtask

  task automatic test_address();
    int sh [6] = '{X0, X0 + W - 1, X0, X0 + W - 1, X0 - 1, X0};
    int sv [6] = '{Y0, Y0, Y0 + 1, Y0 + H - 1, Y0, Y0 + H};
    int sa [6] = '{0, W - 1, W, NPIX - 1, 0, 0};
    int hits;
    logic [31:0] maxa;
    hits = 0;
    maxa = '0;
    for (int c = 0; c < FR; c++) begin
      adv();
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL addr_px t=%0t out=%h want=%h addr=%0d want=%0d",
                   $time, obs, exp_out(h2), fbi.addr_rd, cur.addr);
      end
      if (fbi.addr_rd > maxa) maxa = fbi.addr_rd;
      for (int k = 0; k < 6; k++) begin
        if (cur.en && cur.h == sh[k] && cur.v == sv[k]) begin
          hits++;
          checks++;
          if (fbi.addr_rd !== 32'(sa[k])) begin
            fails++;
            $display("FAIL addr_spot (%0d,%0d) got=%0d want=%0d",
                     sh[k], sv[k], fbi.addr_rd, sa[k]);
          end
        end
      end
    end
    checks++;
    if (hits != 6) begin
      fails++;
      $display("FAIL addr_spot_hits got=%0d want=6", hits);
    end
    checks++;
    if (maxa !== 32'(NPIX - 1)) begin
      fails++;
      $display("FAIL addr_max got=%0d want=%0d", maxa, NPIX - 1);
    end
  endtask

  task automatic test_data();
    for (int i = 0; i < NPIX; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    for (int c = 0; c < FR; c++) begin
      adv();
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL data_px t=%0t out=%h want=%h addr=%0d want=%0d",
                   $time, obs, exp_out(h2), fbi.addr_rd, cur.addr);
      end
      if (h2.en && h2.h == X0 && h2.v == Y0) begin
        checks++;
        if (rgb !== 16'h5A5A || de !== 1'b1) begin
          fails++;
          $display("FAIL data_first rgb=%h de=%b want=5a5a de=1", rgb, de);
        end
      end
      if (h2.en && h2.h == X0 + W - 1 && h2.v == Y0 + H - 1) begin
        checks++;
        if (rgb !== 16'h5B65) begin
          fails++;
          $display("FAIL data_last rgb=%h want=5b65", rgb);
        end
      end
      if (h2.en && h2.h == 10 && h2.v == 10) begin
        checks++;
        if (rgb !== BORDER || de !== 1'b1) begin
          fails++;
          $display("FAIL data_border rgb=%h de=%b want=%h de=1",
                   rgb, de, BORDER);
        end
      end
      if (h2.en && h2.h == 0 && h2.v == 0) begin
        checks++;
        if (fs !== 1'b1 || de !== 1'b1) begin
          fails++;
          $display("FAIL data_sof fs=%b de=%b want fs=1 de=1", fs, de);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int col, guard, dn;
    col = $urandom_range(X0, X0 + W - 1);
    guard = 0;
    while (!(cur.en && cur.h == col && cur.v == Y0 + 5) && guard < FR + 10) begin
      adv();
      guard++;
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL en_seek_px t=%0t out=%h want=%h", $time, obs, exp_out(h2));
      end
    end
    checks++;
    if (guard >= FR + 10) begin
      fails++;
      $display("FAIL en_seek timeout got=%0d want<%0d", guard, FR + 10);
    end
    nxt_en = 1'b0;
    dn = $urandom_range(3, 20);
    for (int c = 1; c <= dn; c++) begin
      adv();
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL en_off_px t=%0t out=%h want=%h", $time, obs, exp_out(h2));
      end
      if (c == 3) begin
        checks++;
        if ({de, hsync, vsync} !== 3'b011) begin
          fails++;
          $display("FAIL en_off de/hs/vs=%b want=011", {de, hsync, vsync});
        end
      end
    end
    nxt_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      adv();
      checks++;
      if (fs !== (c == 3)) begin
        fails++;
        $display("FAIL en_restart_fs c=%0d fs=%b want=%b", c, fs, c == 3);
      end
    end
    guard = 0;
    while (!cur.win && guard < FR) begin
      adv();
      guard++;
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL en_on_px t=%0t out=%h want=%h", $time, obs, exp_out(h2));
      end
    end
    checks++;
    if (guard >= FR || fbi.addr_rd !== 32'd0) begin
      fails++;
      $display("FAIL en_first_addr got=%0d want=0 wait=%0d", fbi.addr_rd, guard);
    end
  endtask

  task automatic test_reset_midline();
    int col, row, guard;
    col = $urandom_range(X0, X0 + W - 1);
    row = $urandom_range(Y0 + 1, Y0 + H - 1);
    guard = 0;
    while (!(cur.en && cur.h == col && cur.v == row) && guard < FR + 10) begin
      adv();
      guard++;
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL rst_seek_px t=%0t out=%h want=%h", $time, obs, exp_out(h2));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 20'h60000 || fbi.addr_rd !== 32'd0 || guard >= FR + 10) begin
      fails++;
      $display("FAIL rst_async out=%h addr=%0d want out=60000 addr=0",
               obs, fbi.addr_rd);
    end
    repeat (3) adv();
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      adv();
      checks++;
      if (obs !== exp_out(h2) || fs !== (c == 2)) begin
        fails++;
        $display("FAIL rst_restart c=%0d out=%h want=%h", c, obs, exp_out(h2));
      end
    end
    guard = 0;
    while (!cur.win && guard < FR) begin
      adv();
      guard++;
    end
    checks++;
    if (guard >= FR || fbi.addr_rd !== 32'd0) begin
      fails++;
      $display("FAIL rst_first_addr got=%0d want=0 wait=%0d", fbi.addr_rd, guard);
    end
  endtask

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [15:0] want;
    rst_n = 1'b0;
    psel = 1'b1;
    adv();
    rst_n = 1'b1;
    for (int c = 0; c < FR + 2; c++) begin
      adv();
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL pat_px t=%0t out=%h want=%h", $time, obs, exp_out(h2));
      end
      if (h2.en && h2.v == Y0 + 3 && h2.h >= X0 - 1 && h2.h < X0 + W) begin
        if (h2.h == X0 - 1) want = BORDER;
        else if (h2.h < X0 + 4) want = 16'hFFFF;
        else if (h2.h < X0 + 8) want = 16'hFFE0;
        else if (h2.h >= X0 + W - 4) want = 16'h0000;
        else want = rgb;
        checks++;
        if (rgb !== want) begin
          fails++;
          $display("FAIL pat_bar col=%0d got=%h want=%h", h2.h, rgb, want);
        end
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    for (int c = 0; c < 12000; c++) begin
      if (en && $urandom_range(0, 2999) == 0) nxt_en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) nxt_en = 1'b1;
      adv();
      checks++;
      if (obs !== exp_out(h2) || fbi.addr_rd !== cur.addr) begin
        fails++;
        if (fails < 30)
          $display("FAIL b2b_px t=%0t out=%h want=%h addr=%0d want=%0d",
                   $time, obs, exp_out(h2), fbi.addr_rd, cur.addr);
      end
    end
  endtask

  initial begin
    fbi.fb_data = '0;
    cur = '0;
    h1 = '0;
    h2 = '0;
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    test_reset();
    test_timing();
    test_address();
    test_data();
    test_enable_drop();
    test_reset_midline();
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    test_pattern();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
